// File: rtl/uart_tx_engine.sv
// UART transmit engine: TX FIFO feeding a 16x-oversampled frame serializer (start, 5-8 data, parity, stop).
// Optional hardware flow control is compiled in with `define UART_TX_CTS_EN (adds the cts_ni port).
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_PTR_W = 4
) (
    input  logic                  clk,
    input  logic                  wb_rst_ni,
    input  logic [7:0]            lcr,
    input  logic                  enable,
    input  logic                  tf_push,
    input  logic [7:0]            tf_data_in,
    input  logic                  tx_reset,
`ifdef UART_TX_CTS_EN
    input  logic                  cts_ni,
`endif
    output logic                  stx_pad_o,
    output logic [FIFO_PTR_W:0]   tf_count,
    output logic                  tf_overrun,
    output logic                  tx_empty,
    output logic [2:0]            tstate
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    localparam logic [FIFO_PTR_W:0] DEPTH_C = (FIFO_PTR_W+1)'(FIFO_DEPTH);

    // Parity over the data bits actually sent; stick parity (SP) overrides with ~EP.
    function automatic logic calc_parity(input logic [7:0] data, input logic [5:0] ctl);
        logic [7:0] mask;
        mask = 8'hFF >> (3'd3 - {1'b0, ctl[1:0]});
        if (ctl[5]) begin
            return ~ctl[4];
        end else if (ctl[4]) begin
            return ^(data & mask);
        end else begin
            return ~^(data & mask);
        end
    endfunction

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    tx_state_e             state_q, state_d;
    logic [3:0]            c16_q, c16_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [3:0]            frame_q, frame_d;
    logic                  par_q, par_d;
    logic                  stx_q, stx_d;
    logic                  tx_empty_q, tx_empty_d;
    logic                  full_s, empty_s, pop_s, push_ok_s, cts_ok_s, line_s;
    logic                  lcr_unused_s;

    assign lcr_unused_s = lcr[7];

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    // Two-flop synchronizer for the asynchronous clear-to-send input.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_ni};
        end
    end
    assign cts_ok_s = ~cts_sync_q[1];
`else
    assign cts_ok_s = 1'b1;
`endif

    assign full_s    = (count_q == DEPTH_C);
    assign empty_s   = (count_q == {(FIFO_PTR_W+1){1'b0}});
    assign pop_s     = enable && (state_q == ST_IDLE) && !empty_s && cts_ok_s && !tx_reset;
    assign push_ok_s = tf_push && (!full_s || pop_s) && !tx_reset;

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= tf_data_in;
        end
    end

    // FIFO pointer, occupancy and sticky overrun next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (tx_reset) begin
            wr_ptr_d  = {FIFO_PTR_W{1'b0}};
            rd_ptr_d  = {FIFO_PTR_W{1'b0}};
            count_d   = {(FIFO_PTR_W+1){1'b0}};
            overrun_d = 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (pop_s)     rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
            else           rd_ptr_d = rd_ptr_q;
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + (FIFO_PTR_W+1)'(1);
                2'b01:   count_d = count_q - (FIFO_PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (tf_push && full_s && !pop_s) overrun_d = 1'b1;
            else                             overrun_d = overrun_q;
        end
    end

    // Frame FSM: everything advances on the baud strobe only; the line is derived from next state.
    always_comb begin
        state_d   = state_q;
        c16_d     = c16_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        frame_d   = frame_q;
        par_d     = par_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_d = mem_q[rd_ptr_q];
                        frame_d = lcr[3:0];
                        par_d   = calc_parity(mem_q[rd_ptr_q], lcr[5:0]);
                        c16_d   = 4'd15;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (c16_q == 4'd0) begin
                        c16_d     = 4'd15;
                        bit_cnt_d = {1'b0, frame_q[1:0]} + 3'd4;
                        state_d   = ST_DATA;
                    end else begin
                        c16_d = c16_q - 4'd1;
                    end
                end
                ST_DATA: begin
                    if (c16_q == 4'd0) begin
                        c16_d   = 4'd15;
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bit_cnt_q == 3'd0) begin
                            state_d = frame_q[3] ? ST_PARITY : ST_STOP1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else begin
                        c16_d = c16_q - 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (c16_q == 4'd0) begin
                        c16_d   = 4'd15;
                        state_d = ST_STOP1;
                    end else begin
                        c16_d = c16_q - 4'd1;
                    end
                end
                ST_STOP1: begin
                    if (c16_q == 4'd0) begin
                        // Second stop bit is only half a bit long for 5-bit words.
                        if (frame_q[2]) begin
                            c16_d   = (frame_q[1:0] == 2'b00) ? 4'd7 : 4'd15;
                            state_d = ST_STOP2;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        c16_d = c16_q - 4'd1;
                    end
                end
                ST_STOP2: begin
                    if (c16_q == 4'd0) state_d = ST_IDLE;
                    else               c16_d   = c16_q - 4'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        case (state_d)
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_d[0];
            ST_PARITY: line_s = par_d;
            default:   line_s = 1'b1;
        endcase
        // Break forces the line low without disturbing frame timing.
        if (lcr[6]) stx_d = 1'b0;
        else        stx_d = line_s;
        tx_empty_d = (count_d == {(FIFO_PTR_W+1){1'b0}}) && (state_d == ST_IDLE);
    end

    // State and status registers.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q   <= {FIFO_PTR_W{1'b0}};
            rd_ptr_q   <= {FIFO_PTR_W{1'b0}};
            count_q    <= {(FIFO_PTR_W+1){1'b0}};
            overrun_q  <= 1'b0;
            state_q    <= ST_IDLE;
            c16_q      <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            frame_q    <= 4'd0;
            par_q      <= 1'b0;
            stx_q      <= 1'b1;
            tx_empty_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
            c16_q      <= c16_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            frame_q    <= frame_d;
            par_q      <= par_d;
            stx_q      <= stx_d;
            tx_empty_q <= tx_empty_d;
        end
    end

    assign stx_pad_o  = stx_q;
    assign tf_count   = count_q;
    assign tf_overrun = overrun_q;
    assign tx_empty   = tx_empty_q;
    assign tstate     = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine; line bits sampled mid-bit on the strobe grid.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       wb_rst_ni = 1'b0;
    logic [7:0] lcr = 8'h03;
    logic       enable = 1'b0;
    logic       tf_push = 1'b0;
    logic [7:0] tf_data_in = 8'h00;
    logic       tx_reset = 1'b0;
`ifdef UART_TX_CTS_EN
    logic       cts_ni = 1'b0;
`endif
    logic       stx_pad_o;
    logic [4:0] tf_count;
    logic       tf_overrun;
    logic       tx_empty;
    logic [2:0] tstate;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.FIFO_DEPTH(16), .FIFO_PTR_W(4)) dut (
        .clk        (clk),
        .wb_rst_ni  (wb_rst_ni),
        .lcr        (lcr),
        .enable     (enable),
        .tf_push    (tf_push),
        .tf_data_in (tf_data_in),
        .tx_reset   (tx_reset),
`ifdef UART_TX_CTS_EN
        .cts_ni     (cts_ni),
`endif
        .stx_pad_o  (stx_pad_o),
        .tf_count   (tf_count),
        .tf_overrun (tf_overrun),
        .tx_empty   (tx_empty),
        .tstate     (tstate)
    );

    task automatic strobe();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        tf_data_in = d;
        tf_push    = 1'b1;
        @(negedge clk);
        tf_push    = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (stx_pad_o !== 1'b1 || tstate !== 3'd0 || tf_count !== 5'd0 ||
            tf_overrun !== 1'b0 || tx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: stx=%b tstate=%0d count=%0d ovr=%b empty=%b, want 1 0 0 0 1",
                     stx_pad_o, tstate, tf_count, tf_overrun, tx_empty);
        end
        wb_rst_ni = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One frame: bits[i] is the expected line value in bit slot i; total = strobes from pop to IDLE.
    task automatic run_frame(input logic [7:0] l, input logic [7:0] d, input logic [15:0] bits,
                             input int nbits, input int total, input string nm);
        int   s;
        logic stop_ok;
        lcr = l;
        push_byte(d);
        n_cmp++;
        if (tstate !== 3'd0 || stx_pad_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s pre_start: tstate=%0d stx=%b want 0 1", nm, tstate, stx_pad_o);
        end
        strobe();
        s = 0;
        lcr = l ^ 8'h3F;
        n_cmp++;
        if (tstate !== 3'd1 || stx_pad_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s start_latency: tstate=%0d stx=%b want 1 0", nm, tstate, stx_pad_o);
        end
        for (int i = 0; i < nbits; i++) begin
            while (s < 8 + 16 * i) begin
                strobe();
                s++;
            end
            n_cmp++;
            if (stx_pad_o !== bits[i]) begin
                n_bad++;
                $display("FAIL %s bit%0d: got %b want %b", nm, i, stx_pad_o, bits[i]);
            end
        end
        stop_ok = 1'b1;
        while (tstate !== 3'd0 && s < 400) begin
            strobe();
            s++;
            if (stx_pad_o !== 1'b1) stop_ok = 1'b0;
        end
        n_cmp++;
        if (s != total) begin
            n_bad++;
            $display("FAIL %s frame_len: got %0d strobes want %0d", nm, s, total);
        end
        n_cmp++;
        if (stop_ok !== 1'b1 || tx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL %s stop_tail: stop_high=%b empty=%b want 1 1", nm, stop_ok, tx_empty);
        end
        lcr = l;
    endtask

    task automatic test_frames();
        run_frame(8'h03, 8'hA5, 16'h034A, 10, 160, "8N1_A5");
        run_frame(8'h1B, 8'h07, 16'h060E, 11, 176, "8E1_07");
        run_frame(8'h0B, 8'h07, 16'h040E, 11, 176, "8O1_07");
        run_frame(8'h04, 8'hF5, 16'h006A, 7, 120, "5N2_F5");
        run_frame(8'h07, 8'h3C, 16'h0278, 10, 176, "8N2_3C");
    endtask

    task automatic test_overrun();
        int s;
        lcr = 8'h03;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        n_cmp++;
        if (tf_count !== 5'd16 || tf_overrun !== 1'b0 || tx_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL fill16: count=%0d ovr=%b empty=%b want 16 0 0", tf_count, tf_overrun, tx_empty);
        end
        tf_data_in = 8'hEE;
        tf_push    = 1'b1;
        enable     = 1'b1;
        @(negedge clk);
        tf_push    = 1'b0;
        enable     = 1'b0;
        s = 0;
        n_cmp++;
        if (tf_count !== 5'd16 || tf_overrun !== 1'b0 || tstate !== 3'd1) begin
            n_bad++;
            $display("FAIL push_pop_full: count=%0d ovr=%b tstate=%0d want 16 0 1", tf_count, tf_overrun, tstate);
        end
        push_byte(8'h11);
        n_cmp++;
        if (tf_count !== 5'd16 || tf_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun: count=%0d ovr=%b want 16 1", tf_count, tf_overrun);
        end
        tx_reset = 1'b1;
        @(negedge clk);
        tx_reset = 1'b0;
        n_cmp++;
        if (tf_count !== 5'd0 || tf_overrun !== 1'b0 || tstate !== 3'd1 || tx_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL flush: count=%0d ovr=%b tstate=%0d empty=%b want 0 0 1 0",
                     tf_count, tf_overrun, tstate, tx_empty);
        end
        while (tstate !== 3'd0 && s < 400) begin
            strobe();
            s++;
        end
        n_cmp++;
        if (s != 160 || tx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_inflight: strobes=%0d empty=%b want 160 1", s, tx_empty);
        end
    endtask

    task automatic test_back_to_back();
        int   s;
        int   idle_seen;
        logic early_empty;
        lcr = 8'h03;
        push_byte(8'h55);
        push_byte(8'hAA);
        push_byte(8'h0F);
        strobe();
        s = 0;
        idle_seen = 0;
        early_empty = 1'b0;
        while (!(tstate === 3'd0 && tf_count === 5'd0) && s < 700) begin
            strobe();
            s++;
            if (tstate === 3'd0) idle_seen++;
            if (tx_empty === 1'b1 && s < 482) early_empty = 1'b1;
        end
        n_cmp++;
        if (s != 482 || idle_seen != 3) begin
            n_bad++;
            $display("FAIL b2b_timing: strobes=%0d idle=%0d want 482 3", s, idle_seen);
        end
        n_cmp++;
        if (early_empty !== 1'b0 || tx_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_empty: early=%b final=%b want 0 1", early_empty, tx_empty);
        end
    endtask

    task automatic test_break();
        int s;
        lcr = 8'h03;
        push_byte(8'hFF);
        strobe();
        s = 0;
        while (s < 24) begin
            strobe();
            s++;
        end
        n_cmp++;
        if (stx_pad_o !== 1'b1) begin
            n_bad++;
            $display("FAIL brk_pre: stx=%b want 1", stx_pad_o);
        end
        lcr = 8'h43;
        @(negedge clk);
        n_cmp++;
        if (stx_pad_o !== 1'b0 || tstate !== 3'd2) begin
            n_bad++;
            $display("FAIL brk_set: stx=%b tstate=%0d want 0 2", stx_pad_o, tstate);
        end
        repeat (16) begin
            strobe();
            s++;
        end
        n_cmp++;
        if (stx_pad_o !== 1'b0 || tstate !== 3'd2) begin
            n_bad++;
            $display("FAIL brk_hold: stx=%b tstate=%0d want 0 2", stx_pad_o, tstate);
        end
        lcr = 8'h03;
        @(negedge clk);
        n_cmp++;
        if (stx_pad_o !== 1'b1) begin
            n_bad++;
            $display("FAIL brk_clear: stx=%b want 1", stx_pad_o);
        end
        while (tstate !== 3'd0 && s < 400) begin
            strobe();
            s++;
        end
        n_cmp++;
        if (s != 160) begin
            n_bad++;
            $display("FAIL brk_len: strobes=%0d want 160", s);
        end
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        int s;
        lcr = 8'h03;
        cts_ni = 1'b1;
        repeat (3) @(negedge clk);
        push_byte(8'h55);
        repeat (4) strobe();
        n_cmp++;
        if (tstate !== 3'd0 || tf_count !== 5'd1) begin
            n_bad++;
            $display("FAIL cts_hold: tstate=%0d count=%0d want 0 1", tstate, tf_count);
        end
        cts_ni = 1'b0;
        repeat (3) @(negedge clk);
        strobe();
        s = 0;
        n_cmp++;
        if (tstate !== 3'd1 || stx_pad_o !== 1'b0) begin
            n_bad++;
            $display("FAIL cts_release: tstate=%0d stx=%b want 1 0", tstate, stx_pad_o);
        end
        while (tstate !== 3'd0 && s < 400) begin
            strobe();
            s++;
        end
        n_cmp++;
        if (s != 160) begin
            n_bad++;
            $display("FAIL cts_len: strobes=%0d want 160", s);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_overrun();
        test_back_to_back();
        test_break();
`ifdef UART_TX_CTS_EN
        test_cts();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
